// File: rtl/lifo_unloader.sv
// -----------------------------------------------------------------------------
// lifo_unloader
//
// Drain stage that sits directly downstream of a LIFO stack. A drain_start
// pulse in IDLE snapshots the LIFO occupancy and pops exactly that many words.
// The words go out on a valid/ready stream through a 2-entry skid buffer,
// newest first. The final word is tagged with m_last, and upstream pushes are
// blocked for the whole drain.
//
// Optional feature macro: LIFO_UNLOADER_ABORT_EN
//   When defined, adds the drain_abort input. It cancels a drain in progress:
//   popping stops, buffered words and any in-flight word are dropped, and the
//   block returns to IDLE without pulsing done.
//
// Ports
//   clk          : clock; all logic runs on its rising edge
//   rst          : synchronous active-high reset
//   drain_abort  : (LIFO_UNLOADER_ABORT_EN only) cancel the current drain
//   drain_start  : one-cycle drain request; honoured only in IDLE
//   lifo_count   : current LIFO occupancy
//   lifo_pop     : pop strobe to the LIFO
//   lifo_rd_data : popped word, valid one cycle after lifo_pop
//   push_block   : high while draining; upstream must not push
//   m_valid      : output word valid
//   m_ready      : downstream accept
//   m_data       : output word (0 while m_valid is low)
//   m_last       : marks the final word of the drain
//   done         : one-cycle pulse in the first IDLE cycle after a drain
// -----------------------------------------------------------------------------
module lifo_unloader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef LIFO_UNLOADER_ABORT_EN
    input  logic              drain_abort,
`endif
    input  logic              drain_start,
    input  logic [CNT_W-1:0]  lifo_count,
    output logic              lifo_pop,
    input  logic [DATA_W-1:0] lifo_rd_data,
    output logic              push_block,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_remaining;   // pops still to issue
    logic [CNT_W-1:0]   r_total;       // words in this drain
    logic [CNT_W-1:0]   r_sent;        // words accepted downstream so far
    logic               r_inflight;    // a pop was issued last cycle
    logic [1:0]         r_occ;         // skid buffer occupancy (0..2)
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_done;
    logic [DATA_W-1:0]  r_buf [2];

    logic               w_hs;
    logic               w_abort;
    logic               w_finish;
    logic               w_buf_wr;
    logic               w_buf_rd;
    logic [2:0]         w_avail;
    logic [2:0]         w_after;
    logic [DATA_W-1:0]  w_head;

`ifdef LIFO_UNLOADER_ABORT_EN
    assign w_abort = (r_state == S_DRAIN) && drain_abort;
`else
    assign w_abort = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Output side. The word returning from the LIFO is forwarded straight
    // to the output when the buffer is empty. This gives first-valid two
    // cycles after drain_start and one word per cycle sustained. If that
    // word is not accepted, it is captured into the buffer, so m_data stays
    // stable under back-pressure.
    // ---------------------------------------------------------------------
    assign m_valid = (r_occ != 2'd0) || r_inflight;
    assign w_head  = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : lifo_rd_data;
    assign m_data  = m_valid ? w_head : '0;
    assign m_last  = m_valid && ((r_sent + CNT_W'(1)) == r_total);
    assign w_hs    = m_valid && m_ready;
    assign done    = r_done;

    // Words held or arriving, and how many remain after this cycle's accept.
    assign w_avail = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_after = w_avail - {2'b00, w_hs};

    // The in-flight word enters the buffer unless it was accepted on the
    // bypass path this cycle.
    assign w_buf_wr = (r_state == S_DRAIN) && !w_abort && r_inflight
                      && !((r_occ == 2'd0) && w_hs);
    assign w_buf_rd = w_hs && (r_occ != 2'd0);

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        lifo_pop     = 1'b0;
        push_block   = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (drain_start) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                push_block = 1'b1;
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    // Pop only if the word would still have a buffer slot
                    // once it arrives.
                    lifo_pop = (r_remaining != '0) && (w_after < 3'd2);
                    // Exit as soon as the final word is accepted, so done
                    // lands in the cycle right after that accept.
                    if ((r_remaining == '0) && (w_after == 3'd0)) begin
                        w_state_next = S_IDLE;
                        w_finish     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Counters and buffer pointers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_total     <= '0;
            r_sent      <= '0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (r_state == S_IDLE) begin
                // Continuously snapshot occupancy so the value seen with
                // drain_start becomes the drain length.
                r_remaining <= lifo_count;
                r_total     <= lifo_count;
                r_sent      <= '0;
                r_inflight  <= 1'b0;
                r_occ       <= 2'd0;
                r_wr_ptr    <= 1'b0;
                r_rd_ptr    <= 1'b0;
            end else if (w_abort) begin
                r_inflight  <= 1'b0;
                r_occ       <= 2'd0;
                r_wr_ptr    <= 1'b0;
                r_rd_ptr    <= 1'b0;
            end else begin
                if (lifo_pop) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
                r_inflight <= lifo_pop;
                if (w_buf_wr) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_buf_rd) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_occ <= r_occ + 2'(w_buf_wr) - 2'(w_buf_rd);
                if (w_hs) begin
                    r_sent <= r_sent + CNT_W'(1);
                end
            end
        end
    end

    // Skid buffer storage. It needs no reset because m_data is gated by
    // m_valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (w_buf_wr && (r_wr_ptr == 1'(gi))) begin
                    r_buf[gi] <= lifo_rd_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_lifo_unloader.sv
// -----------------------------------------------------------------------------
// tb_lifo_unloader
//
// Bench for lifo_unloader. A behavioural LIFO answers pops one cycle later.
// Expected words are queued when each drain is launched, and popped and
// compared on every output handshake. Timing, back-pressure, empty, full,
// re-trigger and reset-mid-drain cases are checked. The abort case is also
// checked when LIFO_UNLOADER_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_lifo_unloader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LOG_N  = 4096;

    logic              clk;
    logic              rst;
    logic              drain_start;
    logic [CNT_W-1:0]  lifo_count;
    logic              lifo_pop;
    logic [DATA_W-1:0] lifo_rd_data;
    logic              push_block;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              done;
`ifdef LIFO_UNLOADER_ABORT_EN
    logic              drain_abort;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] stack[$];

    int n_tests       = 0;
    int n_fail        = 0;
    int cyc           = 0;
    int ready_mode    = 0;
    int n_pop         = 0;
    int n_hs          = 0;
    int n_done        = 0;
    int n_valid       = 0;
    int last_done_cyc = -1;
    int outstanding   = 0;
    int underflow     = 0;
    bit pop_log   [LOG_N];
    bit valid_log [LOG_N];
    bit pb_log    [LOG_N];

    lifo_unloader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef LIFO_UNLOADER_ABORT_EN
        .drain_abort  (drain_abort),
`endif
        .drain_start  (drain_start),
        .lifo_count   (lifo_count),
        .lifo_pop     (lifo_pop),
        .lifo_rd_data (lifo_rd_data),
        .push_block   (push_block),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Behavioural LIFO: a pop seen in a cycle returns the top word next cycle.
    initial begin
        bit p;
        lifo_rd_data = '0;
        lifo_count   = '0;
        forever begin
            @(negedge clk);
            p = lifo_pop;
            @(posedge clk);
            #1;
            if (p) begin
                if (stack.size() > 0) begin
                    lifo_rd_data = stack.pop_back();
                end else begin
                    underflow++;
                    lifo_rd_data = '1;
                end
            end else begin
                lifo_rd_data = $urandom;
            end
            lifo_count = CNT_W'(stack.size());
        end
    end

    // Downstream ready: 0 = always, 1 = toggling, otherwise random.
    initial begin
        m_ready = 1'b1;
        forever begin
            tick;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit                prev_stall;
        logic [DATA_W-1:0] prev_data;
        exp_t              e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (cyc < LOG_N) begin
                pop_log[cyc]   = lifo_pop;
                valid_log[cyc] = m_valid;
                pb_log[cyc]    = push_block;
            end
            if (rst) begin
                exp_q.delete();
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(m_valid), 64'(1));
                    check("hold_data", 64'(m_data), 64'(prev_data));
                end
                if (m_valid) n_valid++;
                if (lifo_pop) begin
                    n_pop++;
                    outstanding++;
                end
                if (m_valid && m_ready) begin
                    n_hs++;
                    outstanding--;
                    $display("[TB] cyc %0d word 0x%08h last %0b", cyc, m_data, m_last);
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 64'(m_data), 64'(e.data));
                        check("m_last", 64'(m_last), 64'(e.last));
                    end
                end
                if (push_block) check("outstanding_le2", 64'(outstanding <= 2), 64'(1));
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
`ifdef LIFO_UNLOADER_ABORT_EN
                if (drain_abort && push_block) begin
                    exp_q.delete();
                    outstanding = 0;
                    prev_stall  = 1'b0;
                end
`endif
                if (done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // Load the LIFO (base+0 at bottom), queue expected words and pulse drain_start.
    task automatic start_drain(input int n, input logic [DATA_W-1:0] base, input int mode,
                               output int t0);
        exp_t e;
        stack.delete();
        for (int i = 0; i < n; i++) stack.push_back(base + DATA_W'(i));
        for (int i = n - 1; i >= 0; i--) begin
            e.data = base + DATA_W'(i);
            e.last = (i == 0);
            exp_q.push_back(e);
        end
        ready_mode = mode;
        tick;
        tick;
        drain_start = 1'b1;
        t0 = cyc;
        tick;
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input int snap, input string tag);
        int k;
        k = 0;
        while (n_done == snap && k < 300) begin
            tick;
            k++;
        end
        check(tag, 64'(n_done > snap), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pop"},   64'(lifo_pop),   64'(0));
        check({tag, "_valid"}, 64'(m_valid),    64'(0));
        check({tag, "_last"},  64'(m_last),     64'(0));
        check({tag, "_data"},  64'(m_data),     64'(0));
        check({tag, "_pb"},    64'(push_block), 64'(0));
        check({tag, "_done"},  64'(done),       64'(0));
    endtask

    initial begin
        int t0, s_hs, s_pop, s_done, s_valid, k, sum;
        rst         = 1'b1;
        drain_start = 1'b0;
`ifdef LIFO_UNLOADER_ABORT_EN
        drain_abort = 1'b0;
`endif
        repeat (3) tick;
        check_reset_outputs("reset");
        tick;
        rst = 1'b0;
        tick;

        // Basic order: 0xA,0xB,0xC with 0xC on top.
        s_hs = n_hs; s_pop = n_pop; s_done = n_done;
        start_drain(3, 32'hA, 0, t0);
        wait_done(s_done, "basic_done_seen");
        tick;
        check("basic_hs", 64'(n_hs - s_hs), 64'(3));
        check("basic_pops", 64'(n_pop - s_pop), 64'(3));
        check("basic_no_pop_c0", 64'(pop_log[t0]), 64'(0));
        check("basic_pop_c1", 64'(pop_log[t0 + 1]), 64'(1));
        check("basic_pb_c1", 64'(pb_log[t0 + 1]), 64'(1));
        check("basic_novalid_c1", 64'(valid_log[t0 + 1]), 64'(0));
        sum = 0;
        for (int i = 2; i <= 4; i++) sum += int'(valid_log[t0 + i]);
        check("basic_valid_c2_4", 64'(sum), 64'(3));
        check("basic_done_cycle", 64'(last_done_cyc - t0), 64'(5));
        check("basic_sb_empty", 64'(exp_q.size()), 64'(0));

        // Back-pressure: 5 words, ready toggling.
        s_hs = n_hs; s_pop = n_pop; s_done = n_done;
        start_drain(5, 32'h100, 1, t0);
        wait_done(s_done, "bp_done_seen");
        tick;
        check("bp_hs", 64'(n_hs - s_hs), 64'(5));
        check("bp_pops", 64'(n_pop - s_pop), 64'(5));
        check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

        // Empty drain.
        s_hs = n_hs; s_pop = n_pop; s_done = n_done; s_valid = n_valid;
        start_drain(0, 32'h0, 0, t0);
        wait_done(s_done, "empty_done_seen");
        tick;
        check("empty_done_cycle", 64'(last_done_cyc - t0), 64'(2));
        check("empty_pb_c1", 64'(pb_log[t0 + 1]), 64'(1));
        check("empty_pb_c2", 64'(pb_log[t0 + 2]), 64'(0));
        check("empty_pops", 64'(n_pop - s_pop), 64'(0));
        check("empty_valid", 64'(n_valid - s_valid), 64'(0));

        // Full LIFO plus a second drain_start mid-drain.
        s_hs = n_hs; s_pop = n_pop; s_done = n_done;
        start_drain(DEPTH, 32'h200, 0, t0);
        repeat (4) tick;
        drain_start = 1'b1;
        tick;
        drain_start = 1'b0;
        wait_done(s_done, "full_done_seen");
        repeat (5) tick;
        check("full_hs", 64'(n_hs - s_hs), 64'(DEPTH));
        check("full_pops", 64'(n_pop - s_pop), 64'(DEPTH));
        check("full_done_cycle", 64'(last_done_cyc - t0), 64'(DEPTH + 2));
        check("full_one_done", 64'(n_done - s_done), 64'(1));
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'(pb_log[last_done_cyc + i]);
        check("full_no_retrigger", 64'(sum), 64'(0));
        check("full_stack_empty", 64'(stack.size()), 64'(0));

        // Reset after the 2nd word of 6, then a fresh 4-word drain.
        s_hs = n_hs;
        start_drain(6, 32'h300, 0, t0);
        k = 0;
        while ((n_hs - s_hs) < 2 && k < 100) begin
            tick;
            k++;
        end
        check("rst_reached_word2", 64'((n_hs - s_hs) >= 2), 64'(1));
        rst = 1'b1;
        tick;
        check_reset_outputs("midrst");
        tick;
        rst = 1'b0;
        tick;
        s_hs = n_hs; s_pop = n_pop; s_done = n_done;
        start_drain(4, 32'h400, 2, t0);
        wait_done(s_done, "post_rst_done_seen");
        tick;
        check("post_rst_hs", 64'(n_hs - s_hs), 64'(4));
        check("post_rst_pops", 64'(n_pop - s_pop), 64'(4));
        check("post_rst_sb_empty", 64'(exp_q.size()), 64'(0));

`ifdef LIFO_UNLOADER_ABORT_EN
        // Abort after the 1st word of 8.
        begin
            int ta;
            s_hs = n_hs; s_done = n_done;
            start_drain(8, 32'h500, 0, t0);
            k = 0;
            while ((n_hs - s_hs) < 1 && k < 100) begin
                tick;
                k++;
            end
            check("abort_reached_word1", 64'((n_hs - s_hs) >= 1), 64'(1));
            drain_abort = 1'b1;
            ta = cyc;
            tick;
            drain_abort = 1'b0;
            @(negedge clk);
            check("abort_valid_low", 64'(m_valid), 64'(0));
            check("abort_pb_low", 64'(push_block), 64'(0));
            repeat (5) tick;
            check("abort_no_pop", 64'(pop_log[ta]), 64'(0));
            check("abort_no_done", 64'(n_done - s_done), 64'(0));
        end
`endif

        check("no_underflow", 64'(underflow), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
